mips_register_file: RTL and testbench



---
 rtl/mips_register_file_pkg.sv | 14 +
 rtl/mips_register_file_if.sv | 32 +++
 rtl/mips_register_file_read_port.sv | 31 +++
 rtl/mips_register_file.sv | 83 ++++++++
 tb/tb_mips_register_file.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/mips_register_file_pkg.sv
// mips_pkg: register-index constants and default widths shared by the
// register file, the main control unit and the RegDst mux.
// Ports: none (package).
package mips_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;   // hard-wired zero register
  localparam reg_idx_t REG_RA   = 5'd31;  // jal link register

endpackage

// File: rtl/mips_register_file_if.sv
// mips_register_file_if: read, write and debug signals of the register file.
// Ports: master = datapath side (drives addresses/write), slave = register file.
// Signals: rd_addr_a/b -> rd_data_a/b, wr_en/wr_addr/wr_data, dbg_addr -> dbg_data, wr_count.
interface mips_register_file_if
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic [15:0]       wr_count;

  modport master (
    output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, dbg_addr,
    input  rd_data_a, rd_data_b, dbg_data, wr_count
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, dbg_addr,
    output rd_data_a, rd_data_b, dbg_data, wr_count
  );

endinterface

// File: rtl/mips_register_file_read_port.sv
// regfile_read_port: combinational read mux with zero-register forcing and
// optional same-cycle write-to-read bypass.
// Ports: regs (full register view), rd_addr -> rd_data; wr_vld/wr_addr/wr_data for bypass.
module regfile_read_port
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter bit BYPASS = 1'b1
) (
  input  logic [DATA_W-1:0] regs [2**ADDR_W],
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wr_vld,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  always_comb begin
    rd_data = regs[rd_addr];
    // rd_addr != 0 together with the equality implies wr_addr != 0,
    // so a discarded write to $0 can never be forwarded.
    if (BYPASS && wr_vld && (wr_addr == rd_addr)) begin
      rd_data = wr_data;
    end
    if (rd_addr == ADDR_W'(REG_ZERO)) begin
      rd_data = '0;
    end
  end

endmodule

// File: rtl/mips_register_file.sv
// mips_register_file: 32-entry register file with async clear, two read ports
// (optionally bypassed), one debug read port and a committed-write counter.
// Ports: clk, reset (async active-high), rf (slave modport: reads, write, debug, wr_count).
module mips_register_file
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter bit BYPASS = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  mips_register_file_if.slave rf
);

  localparam int DEPTH = 2**ADDR_W;

  // Entry 0 has no storage; the read view ties it to zero.
  logic [DATA_W-1:0] regs [1:DEPTH-1];
  logic [DATA_W-1:0] view [DEPTH];
  logic [15:0]       wr_cnt;
  logic              commit;
  logic              byp_vld;

  assign commit  = rf.wr_en && (rf.wr_addr != ADDR_W'(REG_ZERO));
  // Writes are ignored while reset is high, so nothing may be forwarded either.
  assign byp_vld = rf.wr_en && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      wr_cnt <= '0;
    end else if (commit) begin
      regs[rf.wr_addr] <= rf.wr_data;
      wr_cnt           <= wr_cnt + 16'd1;  // wraps naturally
    end
  end

  always_comb begin
    view[0] = '0;
    for (int i = 1; i < DEPTH; i++) begin
      view[i] = regs[i];
    end
  end

  assign rf.wr_count = wr_cnt;

  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_port_a (
    .regs    (view),
    .rd_addr (rf.rd_addr_a),
    .wr_vld  (byp_vld),
    .wr_addr (rf.wr_addr),
    .wr_data (rf.wr_data),
    .rd_data (rf.rd_data_a)
  );

  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_port_b (
    .regs    (view),
    .rd_addr (rf.rd_addr_b),
    .wr_vld  (byp_vld),
    .wr_addr (rf.wr_addr),
    .wr_data (rf.wr_data),
    .rd_data (rf.rd_data_b)
  );

  // Debug peek always shows stored contents.
  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1'b0)) u_port_dbg (
    .regs    (view),
    .rd_addr (rf.dbg_addr),
    .wr_vld  (byp_vld),
    .wr_addr (rf.wr_addr),
    .wr_data (rf.wr_data),
    .rd_data (rf.dbg_data)
  );

  // An unknown write enable, or an unknown target during a write, would
  // corrupt an arbitrary register.
  a_wr_known: assert property (@(posedge clk) disable iff (reset)
    !$isunknown(rf.wr_en) && (!rf.wr_en || !$isunknown(rf.wr_addr)));

endmodule

// File: tb/tb_mips_register_file.sv
// tb_mips_register_file: drives a bypassed and a non-bypassed register file
// with identical directed stimulus and checks both against an array model.
// Ports: none (top-level bench).
module tb_mips_register_file;
  import mips_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_register_file_if #(.DATA_W(32), .ADDR_W(5)) bus_b ();  // BYPASS = 1
  mips_register_file_if #(.DATA_W(32), .ADDR_W(5)) bus_n ();  // BYPASS = 0

  assign bus_n.rd_addr_a = bus_b.rd_addr_a;
  assign bus_n.rd_addr_b = bus_b.rd_addr_b;
  assign bus_n.wr_en     = bus_b.wr_en;
  assign bus_n.wr_addr   = bus_b.wr_addr;
  assign bus_n.wr_data   = bus_b.wr_data;
  assign bus_n.dbg_addr  = bus_b.dbg_addr;

  mips_register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut_b (
    .clk (clk), .reset (reset), .rf (bus_b.slave)
  );
  mips_register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut_n (
    .clk (clk), .reset (reset), .rf (bus_n.slave)
  );

  int checks = 0;
  int errors = 0;
  bit run    = 1'b0;

  // Behavioural model: what each register must hold and how many writes committed.
  logic [31:0] mem [32] = '{default: 32'h0};
  logic [15:0] cnt = 16'h0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
      cnt = 16'h0;
    end else if (bus_b.wr_en && bus_b.wr_addr != 5'd0) begin
      mem[bus_b.wr_addr] = bus_b.wr_data;
      cnt = cnt + 16'd1;
    end
  end

  function automatic logic [31:0] exp_rd(logic [4:0] a, bit byp);
    if (reset || a == 5'd0) return 32'h0;
    if (byp && bus_b.wr_en && bus_b.wr_addr == a) return bus_b.wr_data;
    return mem[a];
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison, sampled on the falling edge.
  always @(negedge clk) begin
    if (run) begin
      chk("b.rd_a",  bus_b.rd_data_a, exp_rd(bus_b.rd_addr_a, 1'b1));
      chk("b.rd_b",  bus_b.rd_data_b, exp_rd(bus_b.rd_addr_b, 1'b1));
      chk("b.dbg",   bus_b.dbg_data,  exp_rd(bus_b.dbg_addr,  1'b0));
      chk("n.rd_a",  bus_n.rd_data_a, exp_rd(bus_b.rd_addr_a, 1'b0));
      chk("n.rd_b",  bus_n.rd_data_b, exp_rd(bus_b.rd_addr_b, 1'b0));
      chk("n.dbg",   bus_n.dbg_data,  exp_rd(bus_b.dbg_addr,  1'b0));
      chk("b.count", {16'h0, bus_b.wr_count}, {16'h0, cnt});
      chk("n.count", {16'h0, bus_n.wr_count}, {16'h0, cnt});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [4:0] a, logic [31:0] d);
    bus_b.wr_en   = 1'b1;
    bus_b.wr_addr = a;
    bus_b.wr_data = d;
    step();
    bus_b.wr_en   = 1'b0;
  endtask

  initial begin
    bus_b.rd_addr_a = 5'd0;
    bus_b.rd_addr_b = 5'd0;
    bus_b.wr_en     = 1'b0;
    bus_b.wr_addr   = 5'd0;
    bus_b.wr_data   = 32'h0;
    bus_b.dbg_addr  = 5'd0;
    run = 1'b1;
    #12 reset = 1'b0;
    step();

    // Reset state
    chk("rst_count", {16'h0, bus_b.wr_count}, 32'h0);

    // Async reset clears r5 before any clock edge; a write pending under reset is dropped
    bus_b.rd_addr_a = 5'd5;
    wr(5'd5, 32'h1234_5678);
    chk("r5_loaded", bus_b.rd_data_a, 32'h1234_5678);
    bus_b.wr_en   = 1'b1;
    bus_b.wr_addr = 5'd7;
    bus_b.wr_data = 32'hAAAA_AAAA;
    #2 reset = 1'b1;
    #1;
    chk("rst_async_a", bus_b.rd_data_a, 32'h0);
    chk("rst_async_n", bus_n.rd_data_a, 32'h0);
    chk("rst_count0",  {16'h0, bus_b.wr_count}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    bus_b.wr_en = 1'b0;
    step();
    bus_b.dbg_addr = 5'd7;
    #1 chk("r7_reset_wins", bus_b.dbg_data, 32'h0);

    // Basic write/read on consecutive edges
    wr(5'd8, 32'hDEAD_BEEF);
    wr(5'd9, 32'h0000_0001);
    bus_b.rd_addr_a = 5'd8;
    bus_b.rd_addr_b = 5'd9;
    #1;
    chk("r8", bus_b.rd_data_a, 32'hDEAD_BEEF);
    chk("r9", bus_b.rd_data_b, 32'h0000_0001);
    chk("count2", {16'h0, bus_b.wr_count}, 32'd2);

    // Writes to $0 are discarded
    bus_b.rd_addr_a = 5'd0;
    bus_b.dbg_addr  = 5'd0;
    wr(5'd0, 32'hFFFF_FFFF);
    chk("r0_a",   bus_b.rd_data_a, 32'h0);
    chk("r0_dbg", bus_b.dbg_data,  32'h0);
    chk("r0_count", {16'h0, bus_b.wr_count}, 32'd2);

    // Bypass: r3 = 0x11 then overwrite with 0x22 while reading it
    wr(5'd3, 32'h11);
    bus_b.rd_addr_a = 5'd3;
    bus_b.rd_addr_b = 5'd3;
    bus_b.dbg_addr  = 5'd3;
    bus_b.wr_en     = 1'b1;
    bus_b.wr_addr   = 5'd3;
    bus_b.wr_data   = 32'h22;
    #1;
    chk("byp_a",     bus_b.rd_data_a, 32'h22);
    chk("byp_b",     bus_b.rd_data_b, 32'h22);
    chk("byp_dbg",   bus_b.dbg_data,  32'h11);
    chk("nobyp_a",   bus_n.rd_data_a, 32'h11);
    chk("nobyp_b",   bus_n.rd_data_b, 32'h11);
    step();
    bus_b.wr_en = 1'b0;
    #1;
    chk("post_a",  bus_b.rd_data_a, 32'h22);
    chk("post_na", bus_n.rd_data_b, 32'h22);
    chk("count4",  {16'h0, bus_b.wr_count}, 32'd4);

    // wr_en low with changing address/data leaves everything unchanged
    for (int i = 0; i < 10; i++) begin
      bus_b.wr_addr = 5'($urandom_range(0, 31));
      bus_b.wr_data = $urandom;
      step();
    end
    for (int i = 0; i < 32; i++) begin
      bus_b.dbg_addr = 5'(i);
      #1;
      chk("sweep_b", bus_b.dbg_data, mem[i]);
      chk("sweep_n", bus_n.dbg_data, mem[i]);
    end
    bus_b.dbg_addr = 5'd8;
    #1 chk("sweep_r8", bus_b.dbg_data, 32'hDEAD_BEEF);
    chk("hold_count", {16'h0, bus_b.wr_count}, 32'd4);

    // Counter wrap: from reset, 65537 writes to r1
    reset = 1'b1;
    #3 reset = 1'b0;
    step();
    bus_b.dbg_addr = 5'd1;
    bus_b.wr_en    = 1'b1;
    bus_b.wr_addr  = 5'd1;
    for (int i = 0; i < 65537; i++) begin
      bus_b.wr_data = 32'(i + 1);
      step();
    end
    bus_b.wr_en = 1'b0;
    #1;
    chk("wrap_count_b", {16'h0, bus_b.wr_count}, 32'd1);
    chk("wrap_count_n", {16'h0, bus_n.wr_count}, 32'd1);
    chk("wrap_r1",      bus_b.dbg_data, 32'h0001_0001);
    step();

    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
